// File: rtl/loop_pkg.sv
// Shared looper types: sample/accumulator widths, mixer state encoding and
// the saturation bounds used wherever a wide sum is folded back to a sample.
package loop_pkg;
  localparam int DATA_W = 16;
  localparam int NBANK  = 8;
  localparam int BANK_W = $clog2(NBANK);
  // Four guard bits: eight banks plus the monitored mic can never overflow.
  localparam int ACC_W  = DATA_W + 4;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [ACC_W-1:0]  acc_t;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    SAT   = 2'd1,
    OUT   = 2'd2
  } mix_state_e;

  localparam acc_t SAT_MAX = acc_t'((1 << (DATA_W - 1)) - 1);
  localparam acc_t SAT_MIN = ~SAT_MAX;

  function automatic acc_t sext(input sample_t s);
    return acc_t'(s);
  endfunction
endpackage

// File: rtl/loop_mixer_sat_clip.sv
// Combinational clamp of a wide signed sum to the sample range, flagging
// whenever the sum had to be clipped.
module sat_clip
  import loop_pkg::*;
(
  input  acc_t    acc_in,
  output sample_t sat_out,
  output logic    clip
);
  always_comb begin
    sat_out = acc_in[DATA_W-1:0];
    clip    = 1'b0;
    if (acc_in > SAT_MAX) begin
      sat_out = SAT_MAX[DATA_W-1:0];
      clip    = 1'b1;
    end else if (acc_in < SAT_MIN) begin
      sat_out = SAT_MIN[DATA_W-1:0];
      clip    = 1'b1;
    end
  end
endmodule

// File: rtl/loop_mixer.sv
// Per-frame bank mixer: sums playing-bank SRAM reads, saturates and publishes
// one sample per frame. Live mic monitoring is enabled by LOOP_MIXER_MONITOR_EN.
module loop_mixer
  import loop_pkg::*;
(
  input  logic              clk_100MHz,
  input  logic              rst,
  input  logic [NBANK-1:0]  playing,
  input  logic [NBANK-1:0]  recording,
  input  logic [BANK_W-1:0] mem_bank,
  input  logic              data_ready,
  input  logic              mix_data,
  input  logic              write_zero,
  input  logic [DATA_W-1:0] mic_sample,
  input  logic              mic_valid,
  input  logic [DATA_W-1:0] ram_dq_in,
  output logic [DATA_W-1:0] ram_dq_out,
  output logic [DATA_W-1:0] mix_out,
  output logic              mix_valid,
  output logic              clip
);
  mix_state_e state_q, state_d;
  acc_t       acc_q, acc_d;
  acc_t       pending_q, pending_d;
  sample_t    mic_hold_q, mic_hold_d;
  sample_t    mix_out_q, mix_out_d;
  logic       clip_q, clip_d;
  logic       mix_valid_q, mix_valid_d;

  acc_t       contrib;
  acc_t       monitor_term;
  sample_t    sat_val;
  logic       sat_flag;

  sat_clip u_sat_clip (
    .acc_in  (acc_q),
    .sat_out (sat_val),
    .clip    (sat_flag)
  );

  // Recording wins over playing: a bank being overdubbed is not played back.
  always_comb begin
    contrib = '0;
    if (data_ready && playing[mem_bank] && !recording[mem_bank])
      contrib = sext(ram_dq_in);
  end

`ifdef LOOP_MIXER_MONITOR_EN
  assign monitor_term = (|recording) ? sext(mic_hold_q) : '0;
`else
  assign monitor_term = '0;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    pending_d   = pending_q;
    mix_out_d   = mix_out_q;
    clip_d      = clip_q;
    mix_valid_d = 1'b0;
    mic_hold_d  = mic_valid ? sample_t'(mic_sample) : mic_hold_q;

    case (state_q)
      ACCUM: begin
        acc_d = acc_q + contrib;
        if (mix_data) begin
          acc_d   = acc_q + contrib + monitor_term;
          state_d = SAT;
        end
      end
      // Result is registered leaving SAT so mix_valid is high during OUT,
      // two cycles after mix_data. A read landing here is parked in pending.
      SAT: begin
        pending_d   = contrib;
        mix_out_d   = sat_val;
        clip_d      = sat_flag;
        mix_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        acc_d     = pending_q + contrib;
        pending_d = '0;
        state_d   = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      pending_q   <= '0;
      mic_hold_q  <= '0;
      mix_out_q   <= '0;
      clip_q      <= 1'b0;
      mix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      pending_q   <= pending_d;
      mic_hold_q  <= mic_hold_d;
      mix_out_q   <= mix_out_d;
      clip_q      <= clip_d;
      mix_valid_q <= mix_valid_d;
    end
  end

  assign ram_dq_out = write_zero ? '0 : mic_hold_q;
  assign mix_out    = mix_out_q;
  assign mix_valid  = mix_valid_q;
  assign clip       = clip_q;
endmodule

// File: tb/tb_loop_mixer.sv
// Directed and randomized bench for loop_mixer against a frame-sum model
// built from plain integer arithmetic and clamping.
module tb_loop_mixer;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  playing, recording;
  logic [2:0]  mem_bank;
  logic        data_ready, mix_data, write_zero, mic_valid;
  logic [15:0] mic_sample, ram_dq_in;
  logic [15:0] ram_dq_out, mix_out;
  logic        mix_valid, clip;

  int n_checks = 0;
  int n_err    = 0;
  logic [15:0] tb_mic = 16'h0000;

  always #5 clk = ~clk;

  loop_mixer dut (
    .clk_100MHz (clk),
    .rst        (rst),
    .playing    (playing),
    .recording  (recording),
    .mem_bank   (mem_bank),
    .data_ready (data_ready),
    .mix_data   (mix_data),
    .write_zero (write_zero),
    .mic_sample (mic_sample),
    .mic_valid  (mic_valid),
    .ram_dq_in  (ram_dq_in),
    .ram_dq_out (ram_dq_out),
    .mix_out    (mix_out),
    .mix_valid  (mix_valid),
    .clip       (clip)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_ready(input logic [2:0] b, input logic [15:0] d);
    mem_bank   = b;
    ram_dq_in  = d;
    data_ready = 1'b1;
    step();
    data_ready = 1'b0;
  endtask

  task automatic load_mic(input logic [15:0] m);
    mic_sample = m;
    mic_valid  = 1'b1;
    step();
    mic_valid  = 1'b0;
    tb_mic     = m;
  endtask

  // Model: total of the frame's terms, clamped to the 16-bit signed range.
  task automatic expect_of(input int sum, output logic [15:0] e, output logic c);
    int s;
    s = sum;
    c = 1'b0;
    if (s > 32767)  begin s = 32767;  c = 1'b1; end
    if (s < -32768) begin s = -32768; c = 1'b1; end
    e = s[15:0];
  endtask

  task automatic do_mix(input string tag, input logic [15:0] e, input logic c);
    mix_data = 1'b1;
    step();
    mix_data = 1'b0;
    check({tag, "_valid_early"}, {31'b0, mix_valid}, 32'd0);
    step();
    check({tag, "_valid"}, {31'b0, mix_valid}, 32'd1);
    check({tag, "_out"}, {16'b0, mix_out}, {16'b0, e});
    check({tag, "_clip"}, {31'b0, clip}, {31'b0, c});
    step();
    check({tag, "_valid_width"}, {31'b0, mix_valid}, 32'd0);
    $display("mix %s: out=%04h clip=%0d expected=%04h/%0d", tag, mix_out, clip, e, c);
  endtask

  function automatic int mon_term(input logic [7:0] rec);
    logic signed [15:0] m;
    m = tb_mic;
`ifdef LOOP_MIXER_MONITOR_EN
    return (rec != 8'h00) ? int'(m) : 0;
`else
    return (rec != 8'h00 && 1'b0) ? int'(m) : 0;
`endif
  endfunction

  initial begin
    logic [15:0] e;
    logic        c;
    int          sum;
    logic signed [15:0] ds;
    logic [15:0] d;

    rst = 1'b1; playing = '0; recording = '0; mem_bank = '0;
    data_ready = 0; mix_data = 0; write_zero = 0; mic_valid = 0;
    mic_sample = '0; ram_dq_in = '0;
    step(); step();
    rst = 1'b0;
    check("rst_mix_out", {16'b0, mix_out}, 32'd0);
    check("rst_valid", {31'b0, mix_valid}, 32'd0);
    check("rst_clip", {31'b0, clip}, 32'd0);
    check("rst_dq_out", {16'b0, ram_dq_out}, 32'd0);

    // Basic two-bank sum
    playing = 8'h05;
    pulse_ready(3'd0, 16'h1000);
    pulse_ready(3'd2, 16'h0200);
    pulse_ready(3'd1, 16'h4444);   // not playing
    do_mix("basic", 16'h1200, 1'b0);

    // Positive and negative saturation
    playing = 8'h0F;
    for (int b = 0; b < 4; b++) pulse_ready(3'(b), 16'h7000);
    do_mix("sat_pos", 16'h7FFF, 1'b1);
    for (int b = 0; b < 4; b++) pulse_ready(3'(b), 16'h9000);
    do_mix("sat_neg", 16'h8000, 1'b1);

    // Recording suppresses playback of the same bank
    playing = 8'h01; recording = 8'h01;
    pulse_ready(3'd0, 16'h1234);
    do_mix("rec_prio", 16'h0000, 1'b0);

    // Mic hold and erase path
    load_mic(16'h0ABC);
    check("dq_mic", {16'b0, ram_dq_out}, 32'h0ABC);
    write_zero = 1'b1;
    #1;
    check("dq_zero", {16'b0, ram_dq_out}, 32'd0);
    write_zero = 1'b0;
    #1;
    check("dq_back", {16'b0, ram_dq_out}, 32'h0ABC);
    recording = 8'h00;

    // Coincident data_ready + mix_data, then a read landing in SAT
    playing = 8'h02;
    mem_bank = 3'd1; ram_dq_in = 16'h0010; data_ready = 1'b1; mix_data = 1'b1;
    step();
    mix_data = 1'b0; ram_dq_in = 16'h0020;   // now in SAT
    step();
    data_ready = 1'b0;
    check("coinc_valid", {31'b0, mix_valid}, 32'd1);
    check("coinc_out", {16'b0, mix_out}, 32'h0010);
    step();
    do_mix("pending", 16'h0020, 1'b0);

    // Live monitoring
    load_mic(16'h0100);
    playing = 8'h01; recording = 8'h02;
    pulse_ready(3'd0, 16'h0001);
`ifdef LOOP_MIXER_MONITOR_EN
    do_mix("monitor", 16'h0101, 1'b0);
`else
    do_mix("monitor", 16'h0001, 1'b0);
`endif
    recording = 8'h00;

    // Reset while in SAT
    playing = 8'h01;
    pulse_ready(3'd0, 16'h0300);
    mix_data = 1'b1;
    step();
    mix_data = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    tb_mic = 16'h0000;
    check("rstsat_valid", {31'b0, mix_valid}, 32'd0);
    check("rstsat_out", {16'b0, mix_out}, 32'd0);
    check("rstsat_dq", {16'b0, ram_dq_out}, 32'd0);
    step();
    check("rstsat_valid2", {31'b0, mix_valid}, 32'd0);
    pulse_ready(3'd0, 16'h0005);
    do_mix("after_rst", 16'h0005, 1'b0);

    // Randomized frames against the model
    for (int f = 0; f < 30; f++) begin
      if ($urandom_range(0, 2) == 0) load_mic(16'($urandom));
      playing   = 8'($urandom);
      recording = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      write_zero = ($urandom_range(0, 4) == 0);
      sum = 0;
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(0, 3) != 0) begin
          d = (f % 3 == 0) ? (16'h6000 | 16'($urandom_range(0, 4095))) : 16'($urandom);
          pulse_ready(3'(b), d);
          ds = d;
          if (playing[b] && !recording[b]) sum += int'(ds);
          if ($urandom_range(0, 1) == 0) step();
        end
      end
      sum += mon_term(recording);
      expect_of(sum, e, c);
      do_mix($sformatf("rand%0d", f), e, c);
      write_zero = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
